// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and widths for the arithmetic-unit front end
package alu_seq_pkg;

    localparam int RES_W  = 8;
    localparam int OPND_W = 4;

    typedef enum logic [1:0] {
        OP_RSVD = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADD  = 2'b10,
        OP_MUL  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - power-of-two result queue with push/pop and occupancy outputs
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head reads as zero when empty so stale storage never reaches the outputs.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered request/settle/capture front end for the 4-bit arithmetic unit
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int DEPTH         = 4,
    parameter int TAG_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);
    localparam int PAY_W = RES_W + TAG_W + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        settle_cnt;
    logic [TAG_W-1:0]  tag_q;
    logic              accept;
    logic              capture;
    logic              op_err;
    logic [RES_W-1:0]  cap_result;
    logic [PAY_W-1:0]  push_data;
    logic [PAY_W-1:0]  head_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Only one request is ever in flight, so a free slot at accept time guarantees room at capture.
    assign in_ready = rst_n && (state == IDLE) && (fifo_count < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tag_q      <= '0;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_op     <= in_op;
                tag_q      <= in_tag;
                settle_cnt <= 4'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers are left untouched after capture to keep the unit inputs quiet.
    assign op_err     = (alu_op == OP_RSVD);
    assign cap_result = op_err ? '0 : alu_result;
    assign push_data  = {cap_result, tag_q, op_err};

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture && !fifo_full),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign {out_result, out_tag, out_err} = head_data;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - table and scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tag;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [3:0] in_a, in_b, in_tag, alu_a, alu_b, out_tag;
    logic [1:0] in_op, alu_op;
    logic [7:0] alu_result, out_result;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
    logic [3:0] in_a3, in_b3, in_tag3, alu_a3, alu_b3, out_tag3;
    logic [1:0] in_op3, alu_op3;
    logic [7:0] alu_result3, out_result3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    // Behavioural stand-in for the arithmetic unit; reserved opcode yields junk to prove forcing.
    function automatic logic [7:0] unit_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'b10:   return {4'd0, a} + {4'd0, b};
            2'b01:   return {4'd0, a} - {4'd0, b};
            2'b11:   return {4'd0, a} * {4'd0, b};
            default: return 8'hAA;
        endcase
    endfunction

    assign alu_result  = unit_model(alu_a, alu_b, alu_op);
    assign alu_result3 = unit_model(alu_a3, alu_b3, alu_op3);

    alu_op_sequencer #(.SETTLE_CYCLES(1), .DEPTH(4), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3), .DEPTH(4), .TAG_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_op(in_op3), .in_tag(in_tag3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
        .out_tag(out_tag3), .out_err(out_err3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every pop of the S=1 instance is matched against the queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %0h tag %0h, expected no output", out_result, out_tag);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_result", 32'(out_result), 32'(mon_e.res));
                check("sb_tag", 32'(out_tag), 32'(mon_e.tag));
                check("sb_err", 32'(out_err), 32'(mon_e.err));
            end
        end
    end

    task automatic send_req(input vec_t v, output int hs);
        int   n;
        exp_t e;
        in_a = v.a; in_b = v.b; in_op = v.op; in_tag = v.tag; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %0b, expected 1", in_ready);
            in_valid = 1'b0;
            hs = -1;
        end else begin
            e.res = v.exp_res; e.tag = v.tag; e.err = v.exp_err;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            hs = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic send3(input vec_t v, output int hs);
        int n;
        in_a3 = v.a; in_b3 = v.b; in_op3 = v.op; in_tag3 = v.tag; in_valid3 = 1'b1;
        n = 0;
        while (!in_ready3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready3) begin
            checks++;
            errors++;
            $display("FAIL send3_timeout: in_ready3 %0b, expected 1", in_ready3);
            hs = -1;
        end else begin
            @(posedge clk);
            #1;
            hs = cyc;
        end
        in_valid3 = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_out_result"}, 32'(out_result), 32'd0);
        check({pfx, "_out_tag"}, 32'(out_tag), 32'd0);
        check({pfx, "_out_err"}, 32'(out_err), 32'd0);
        check({pfx, "_alu_a"}, 32'(alu_a), 32'd0);
        check({pfx, "_alu_b"}, 32'(alu_b), 32'd0);
        check({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        int hs, hs2, lat, n, stale;

        vecs[0] = '{OP_ADD,  4'd3,  4'd5,  4'd1,  8'h08, 1'b0};
        vecs[1] = '{OP_MUL,  4'd15, 4'd15, 4'd2,  8'hE1, 1'b0};
        vecs[2] = '{OP_SUB,  4'd2,  4'd7,  4'd3,  8'hFB, 1'b0};
        vecs[3] = '{OP_RSVD, 4'd9,  4'd9,  4'd4,  8'h00, 1'b1};
        vecs[4] = '{OP_ADD,  4'd15, 4'd15, 4'd5,  8'h1E, 1'b0};
        vecs[5] = '{OP_SUB,  4'd9,  4'd3,  4'd6,  8'h06, 1'b0};
        vecs[6] = '{OP_MUL,  4'd7,  4'd6,  4'd7,  8'h2A, 1'b0};
        vecs[7] = '{OP_MUL,  4'd15, 4'd0,  4'd15, 8'h00, 1'b0};

        rst_n = 1'b0; out_ready = 1'b1; out_ready3 = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_op3 = '0; in_tag3 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_in_ready", 32'(in_ready), 32'd1);

        // ADD 3+5: out_valid appears after edge E0+S+1 (S+2 cycles counting the handshake cycle).
        send_req(vecs[0], hs);
        n = 0; lat = -1;
        while (n < 50) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - hs;
                break;
            end
            n++;
        end
        check("add_latency_edges", 32'(lat), 32'd2);
        drain();

        // Back-to-back MUL then SUB: second request stalls until IDLE.
        send_req(vecs[1], hs);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        send_req(vecs[2], hs2);
        check("stall_spacing", 32'(hs2 - hs), 32'd3);
        drain();

        // FIFO full with consumer stalled; one pop re-opens the request port.
        out_ready = 1'b0;
        for (int i = 3; i < 7; i++) begin
            send_req(vecs[i], hs);
        end
        repeat (3) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head_tag", 32'(out_tag), 32'(vecs[3].tag));
        check("full_head_err", 32'(out_err), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("pop_in_ready", 32'(in_ready), 32'd1);
        send_req(vecs[7], hs);
        drain();

        // SETTLE_CYCLES=3: pop of the old head and capture of the new result on one edge.
        send3(vecs[0], hs);
        n = 0; lat = -1;
        while (n < 50) begin
            @(negedge clk);
            if (out_valid3) begin
                lat = cyc - hs;
                break;
            end
            n++;
        end
        check("s3_first_latency_edges", 32'(lat), 32'd4);
        send3(vecs[2], hs);
        repeat (3) @(posedge clk);
        #1 out_ready3 = 1'b1;
        @(negedge clk);
        check("s3_pre_tag", 32'(out_tag3), 32'(vecs[0].tag));
        check("s3_pre_count", 32'(u_dut3.u_fifo.count), 32'd1);
        @(posedge clk);
        #1 out_ready3 = 1'b0;
        @(negedge clk);
        check("s3_post_count", 32'(u_dut3.u_fifo.count), 32'd1);
        check("s3_post_valid", 32'(out_valid3), 32'd1);
        check("s3_post_tag", 32'(out_tag3), 32'(vecs[2].tag));
        check("s3_post_result", 32'(out_result3), 32'(vecs[2].exp_res));
        check("s3_latency_edges", 32'(cyc - hs), 32'd4);

        // Reset while a request is settling.
        out_ready = 1'b1;
        send_req(vecs[4], hs);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_settle");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_settle_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_settle_no_stale", 32'(stale), 32'd0);

        // Reset while the FIFO is full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_req(vecs[i], hs);
        end
        repeat (3) @(negedge clk);
        check("rst_full_pre_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_full");
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_full_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_full_no_stale", 32'(stale), 32'd0);
        send_req(vecs[5], hs);
        drain();

        // Whole table streamed with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            send_req(vecs[i], hs);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered front end for the 4-bit add/mul/sub combinational unit. It accepts operation requests on a valid/ready interface and drives the unit's operand and operation pins from registers. It waits a programmable settle time, then captures the 8-bit result into a small result FIFO that is drained on a second valid/ready interface. It sits directly upstream of the arithmetic unit, feeds its `a`, `b` and `operation` inputs, and consumes its `Result` outputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the unit's inputs are held before capture; legal range 1..15.
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `TAG_W`, default 4: width of the request tag carried alongside each result.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: request accepted on the same edge where valid && ready.
- `in_a`  in  4: operand a.
- `in_b`  in  4: operand b.
- `in_op`  in  2: operation code.
- `in_tag`  in  TAG_W: opaque tag.
- `alu_a`  out  4: registered drive to the unit's `a_3_..a_0_`.
- `alu_b`  out  4: registered drive to the unit's `b_3_..b_0_`.
- `alu_op`  out  2: registered drive to the unit's `operation_1_, operation_0_`.
- `alu_result`  in  8: from the unit's `Result_7_..Result_0_`.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: consumer pops the head on valid && ready.
- `out_result`  out  8: FIFO head result.
- `out_tag`  out  TAG_W: FIFO head tag.
- `out_err`  out  1: FIFO head was a reserved opcode.

## Operation
- Opcodes:
  - `OP_RSVD` = 2'b00
  - `OP_SUB` = 2'b01
  - `OP_ADD` = 2'b10
  - `OP_MUL` = 2'b11
- FSM states and transitions:
  - IDLE → SETTLE when a request is accepted.
  - SETTLE → CAPTURE when the settle counter expires.
  - CAPTURE → IDLE unconditionally.
- `in_ready` = (state == IDLE) && (fifo_count < DEPTH). At most one request is in flight, so a push never overflows.
- On accept:
  - `alu_a`, `alu_b`, `alu_op` and a tag holding register are loaded from the request.
  - The settle counter is loaded with `SETTLE_CYCLES - 1`.
- SETTLE: the counter decrements each cycle and the state leaves SETTLE when the counter is 0.
- CAPTURE: pushes {`alu_result`, tag, err} into the FIFO.
  - err = (op == `OP_RSVD`).
  - If err, the pushed result is forced to 8'h00.
- After capture, `alu_a`, `alu_b` and `alu_op` hold their last values. They do not return to zero, so the unit's inputs do not toggle needlessly.
- FIFO: a push and a pop in the same cycle are both honoured, and the count is unchanged. Pointers wrap modulo DEPTH.
- Width rules:
  - `alu_result` is captured verbatim with no re-extension.
  - ADD/SUB carry and borrow encoding is defined by the unit, not by this block.

## Timing
- Reset (`rst_n` low at an edge), applied after that edge:
  - state = IDLE
  - `alu_a`, `alu_b`, `alu_op` = 0
  - counter = 0
  - FIFO empty
  - `out_valid` = 0
  - `out_result`, `out_tag`, `out_err` = 0
  - `in_ready` = 0 while `rst_n` is low, and 1 on the first cycle after release.
- Reset mid-operation: an in-flight request is discarded, the FIFO contents are lost, and no partial push occurs.
- Latency, with the FIFO empty and the handshake at edge E0:
  - `alu_*` are valid after E0.
  - The capture edge is E(SETTLE_CYCLES+1).
  - `out_valid` is high after that edge: SETTLE_CYCLES+2 cycles.
- Throughput: one request per SETTLE_CYCLES+2 cycles. `in_ready` is low during SETTLE and CAPTURE.
- FIFO full: `in_ready` stays low until a pop. A pop at edge E makes `in_ready` high after E.
- `out_*` are driven from registers/FIFO storage only, with no combinational path from `in_*` or `alu_result`.
- `out_valid` must stay high and the head must stay stable until it is popped.

## Structure
- Package `alu_seq_pkg`:
  - `op_t` enum and the OP_* constants.
  - `state_t` (IDLE/SETTLE/CAPTURE).
  - Result width constant `RES_W` = 8.
  - Operand width constant `OPND_W` = 4.
- One sub-module `alu_result_fifo`: parameterised by DEPTH and payload width, with a push/pop interface and count/full/empty outputs.
- The FSM and operand registers stay in the top module.
- The arithmetic unit is instantiated outside this block.

## Test plan
- Reset, then ADD with a=3, b=5 and SETTLE=1, with the bench modelling the unit:
  - `out_valid` is high exactly 3 cycles after the handshake.
  - `out_result` = 8'h08, with the correct tag and `out_err` = 0.
- MUL with a=15, b=15, then SUB with a=2, b=7, back-to-back `in_valid`:
  - The second request is stalled until IDLE.
  - Results are 8'hE1 and the unit's SUB encoding, in order, with tags preserved.
- `out_ready` held low, 4 requests issued with DEPTH=4:
  - `in_ready` goes low after the 4th capture.
  - A single pop re-raises `in_ready` on the next cycle.
  - The 5th request completes.
- Reserved op 2'b00 with a=9, b=9: result 8'h00 with `out_err` = 1.
- SETTLE_CYCLES=3 with a pop and a push on the same edge: the FIFO count is unchanged and the latency is 5 cycles.
- `rst_n` asserted during SETTLE and during a full FIFO:
  - Next cycle `out_valid` = 0 and all outputs = 0.
  - `in_ready` = 1 on the first cycle after release.
  - No stale result appears.
